// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - divider state encodings, handshake levels and helpers
package div_pkg;

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div.sv
// rtl/div.sv - iterative radix-2 restoring divider for DIV/DIVU in the execute stage
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [64:0] dividend;
  logic [31:0] divisor;
  logic        sign_q;
  logic        sign_r;

  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] diff;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Magnitudes feed the unsigned core; signs are restored once the loop ends.
  assign abs1 = (signed_div && opdata1[31]) ? neg32(opdata1) : opdata1;
  assign abs2 = (signed_div && opdata2[31]) ? neg32(opdata2) : opdata2;

  assign diff = dividend[64:32] - {1'b0, divisor};

  assign quot_fix = sign_q ? neg32(dividend[31:0])  : dividend[31:0];
  assign rem_fix  = sign_r ? neg32(dividend[64:33]) : dividend[64:33];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= 6'd0;
      dividend <= 65'd0;
      divisor  <= ZERO_WORD;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result   <= {ZERO_WORD, ZERO_WORD};
      ready    <= DIV_RESULT_NOT_READY;
    end else if (annul) begin
      state  <= DIV_FREE;
      result <= {ZERO_WORD, ZERO_WORD};
      ready  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result <= {ZERO_WORD, ZERO_WORD};
          ready  <= DIV_RESULT_NOT_READY;
          if (start == DIV_START) begin
            divisor <= abs2;
            sign_q  <= signed_div & (opdata1[31] ^ opdata2[31]);
            sign_r  <= signed_div & opdata1[31];
            if (opdata2 == ZERO_WORD) begin
              state <= DIV_BY_ZERO;
            end else begin
              dividend <= {ZERO_WORD, abs1, 1'b0};
              cnt      <= 6'd0;
              state    <= DIV_ON;
            end
          end
        end
        DIV_BY_ZERO: begin
          result <= {ZERO_WORD, ZERO_WORD};
          ready  <= DIV_RESULT_READY;
          state  <= DIV_END;
        end
        DIV_ON: begin
          if (cnt != 6'd32) begin
            // Partial remainder sits in [64:33]; quotient bits shift in at [0].
            if (diff[32]) begin
              dividend <= {dividend[63:0], 1'b0};
            end else begin
              dividend <= {diff[31:0], dividend[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            result <= {rem_fix, quot_fix};
            ready  <= DIV_RESULT_READY;
            cnt    <= 6'd0;
            state  <= DIV_END;
          end
        end
        DIV_END: begin
          if (start == DIV_STOP) begin
            result <= {ZERO_WORD, ZERO_WORD};
            ready  <= DIV_RESULT_NOT_READY;
            state  <= DIV_FREE;
          end
        end
        default: begin
          state <= DIV_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - self-checking bench for div against an arithmetic reference model
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_vec = 0;
  int n_bad = 0;

  div dut (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {remainder, quotient} as DIV/DIVU define it; divide by zero yields 0.
  function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sd) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_ready(input string tag, input int lat);
    int cyc;
    cyc = 0;
    while (!ready && cyc < 60) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
  endtask

  // One divide following the hazard rule: start held until ready, dropped in the ready cycle.
  task automatic run_div(input string tag, input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold);
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    tick();
    opdata1    = $urandom;
    opdata2    = $urandom;
    signed_div = 1'($urandom);
    wait_ready(tag, (b == 32'd0) ? 1 : 33);
    check({tag, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold ready"}, 64'(ready), 64'd1);
      check({tag, " hold result"}, result, exp);
    end
    start = 1'b0;
    tick();
    check({tag, " release ready"}, 64'(ready), 64'd0);
    check({tag, " release result"}, result, 64'd0);
  endtask

  initial begin
    bit          any_ready;
    bit          sd;
    logic [31:0] a;
    logic [31:0] b;

    rst        = 1'b1;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    #1;
    check("reset ready", 64'(ready), 64'd0);
    check("reset result", result, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle ready", 64'(ready), 64'd0);

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 0);
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 0);
    run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 0);
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 64'd0, 2);

    // annul sampled at T+11, new divide sampled at T+12
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = 1'b1;
    tick();
    any_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_ready |= ready;
    end
    annul = 1'b1;
    tick();
    any_ready |= ready;
    annul = 1'b0;
    check("annul ready low", 64'(any_ready), 64'd0);
    tick();
    wait_ready("after annul", 33);
    check("after annul result", result, 64'h00000001_0000014D);
    start = 1'b0;
    tick();
    check("after annul release", 64'(ready), 64'd0);

    // annul coinciding with completion
    opdata1 = 32'd77;
    opdata2 = 32'd5;
    start   = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) tick();
    annul = 1'b1;
    start = 1'b0;
    tick();
    annul = 1'b0;
    any_ready = ready;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_ready |= ready;
    end
    check("annul at done ready", 64'(any_ready), 64'd0);
    check("annul at done result", result, 64'd0);

    // start dropping during the loop does not stop it
    signed_div = 1'b1;
    opdata1    = 32'hFFFF_FF9C;
    opdata2    = 32'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_ready("start drop", 33);
    check("start drop result", result, ref_div(1'b1, 32'hFFFF_FF9C, 32'd7));
    tick();
    check("start drop release", 64'(ready), 64'd0);

    // asynchronous reset mid-divide at T+20
    signed_div = 1'b0;
    opdata1    = 32'd12345;
    opdata2    = 32'd11;
    start      = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    #2 rst = 1'b1;
    start = 1'b0;
    #1;
    check("rst mid ready", 64'(ready), 64'd0);
    check("rst mid result", result, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run_div("after rst", 1'b0, 32'd12345, 32'd11, 64'h00000003_00000462, 0);

    // asynchronous reset while a result is presented
    signed_div = 1'b0;
    opdata1    = 32'd9;
    opdata2    = 32'd0;
    start      = 1'b1;
    tick();
    wait_ready("rst end", 1);
    #2 rst = 1'b1;
    #1;
    check("rst end ready", 64'(ready), 64'd0);
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // back-to-back randomized divides
    for (int n = 0; n < 40; n++) begin
      sd = 1'($urandom);
      a  = pick();
      b  = pick();
      run_div($sformatf("rand%0d %s %h/%h", n, sd ? "div" : "divu", a, b), sd, a, b, ref_div(sd, a, b), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
